aximm_user_responder: RTL and testbench
=======================================

AXIMM_USER_RESPONDER -- requirements
Module: aximm_user_responder

Interface
REQ-001 SHALL have parameter AXI_TDATA_FACTOR, default 2, data width is 64*AXI_TDATA_FACTOR bits (default 128).
REQ-002 SHALL have parameter MEM_DEPTH, default 256, number of data words in the backing store (power of 2).
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 SHALL have port clk_wr, input, 1 bit, the only clock.
REQ-005 SHALL have port rst_wr, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have the AR ports user_arid (in, 4), user_arsize (in, 3), user_arlen (in, 8), user_arburst (in, 2), user_araddr (in, 32), user_arvalid (in, 1) and user_arready (out, 1).
REQ-007 SHALL have the AW ports user_awid (in, 4), user_awsize (in, 3), user_awlen (in, 8), user_awburst (in, 2), user_awaddr (in, 32), user_awvalid (in, 1) and user_awready (out, 1).
REQ-008 SHALL have the W ports user_wid (in, 4, ignored), user_wdata (in, 64*AXI_TDATA_FACTOR), user_wstrb (in, 16, only the low 8*AXI_TDATA_FACTOR bits used), user_wlast (in, 1), user_wvalid (in, 1) and user_wready (out, 1).
REQ-009 SHALL have the R ports user_rid (out, 4), user_rdata (out, 64*AXI_TDATA_FACTOR), user_rlast (out, 1), user_rresp (out, 2), user_rvalid (out, 1) and user_rready (in, 1).
REQ-010 SHALL have the B ports user_bid (out, 4), user_bresp (out, 2), user_bvalid (out, 1) and user_bready (in, 1).
REQ-011 SHALL have port responder_debug_status, output, 32 bits, {rd_burst_cnt[15:0], wr_burst_cnt[15:0]}.

Function
REQ-012 SHALL run independent write FSM (W_IDLE, W_DATA, W_RESP) and read FSM (R_IDLE, R_DATA); the size fields are ignored and every beat is one full data word.
REQ-013 Word index SHALL be addr[ADDR_LSB+log2(MEM_DEPTH)-1:ADDR_LSB], ADDR_LSB=log2(8*AXI_TDATA_FACTOR) (4 by default); the index wraps modulo MEM_DEPTH.
REQ-014 W_IDLE SHALL drive user_awready=1; on an AW handshake it captures id/addr/len/burst, clears the beat counter and goes to W_DATA.
REQ-015 W_DATA SHALL drive user_wready=1; each W handshake writes the strobe-enabled bytes into mem[idx]; burst FIXED (2'b00) holds idx, INCR (2'b01) and all other codes do idx+1.
REQ-016 The write burst SHALL end on the beat where beat counter==awlen, then go to W_RESP.
REQ-017 bresp SHALL be OKAY (2'b00), or SLVERR (2'b10) if awburst is 2'b10/2'b11 or if wlast disagrees with the expected final beat on any beat.
REQ-018 W_RESP SHALL hold user_bvalid=1 with stable bid/bresp until user_bready=1; it then returns to W_IDLE and increments wr_burst_cnt (wraps at 16 bits).
REQ-019 R_IDLE SHALL drive user_arready=1; on an AR handshake it captures the fields and enters R_DATA, with user_rvalid asserted on the next cycle.
REQ-020 R_DATA SHALL drive user_rvalid=1, user_rdata=mem[idx] (combinational array read), user_rid=captured id, and user_rlast=1 when beat==arlen; rresp follows the same burst-code rule as REQ-017.
REQ-021 Outputs SHALL be held stable while rvalid&&!rready; on each R handshake idx/beat advance, and after the last beat the FSM returns to R_IDLE and rd_burst_cnt increments.
REQ-022 Back-to-back: user_arready/user_awready SHALL be 0 outside idle, so there is one outstanding burst per direction.
REQ-023 For a same-cycle read and write to the same word, the read SHALL return pre-write data.
REQ-024 awlen/arlen=0 SHALL be a single-beat burst; 255 SHALL be 256 beats.

Reset
REQ-025 rst_wr=1 SHALL force both FSMs to idle, all valid/ready/rlast outputs to 0, the id/resp/rdata outputs to 0, and both burst counters to 0, including mid-burst; ready outputs rise the cycle after reset deasserts.
REQ-026 Memory contents SHALL NOT be reset.

Structure
REQ-027 Package aximm_resp_pkg SHALL hold the FSM state enums, BURST_FIXED/BURST_INCR, and RESP_OKAY/RESP_SLVERR constants.
REQ-028 Sub-module aximm_resp_mem SHALL implement the MEM_DEPTH x data-width register array with per-byte write strobes and an async read port.

Verification
REQ-029 AW id=3, addr=0x20, len=3, INCR; 4 beats of data D0..D3 with full strobes -> bvalid with bid=3, bresp=0; mem[2..5]=D0..D3; wr_burst_cnt=1.
REQ-030 AR id=5, addr=0x20, len=3 with rready toggling 1/0 -> 4 beats D0..D3 in order, rlast only on the 4th beat, data stable while stalled, rid=5.
REQ-031 Write addr=0x10, wstrb=16'h00FF, data all-ones over a word of zeros -> a read returns low 8 bytes 0xFF and high 8 bytes 0x00.
REQ-032 AW len=1 with wlast=1 on beat 0 -> bresp=2'b10; burst 2'b10 read -> every rresp=2'b10.
REQ-033 MEM_DEPTH=256, INCR write at word 255, len=1 -> the second beat lands in word 0.
REQ-034 rst_wr asserted mid-read burst (beat 2 of 8) -> next cycle rvalid=0, arready=0, debug_status=0; a fresh AR after reset completes correctly.

Source files
------------

// File: rtl/aximm_resp_pkg.sv
// Shared types and constants for the AXI-MM user responder.
package aximm_resp_pkg;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wr_state_e;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rd_state_e;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // WRAP (2'b10) and reserved (2'b11) codes are not supported and get SLVERR.
   function automatic logic burst_unsupported(input logic [1:0] burst);
      return burst[1];
   endfunction

endpackage

// File: rtl/aximm_resp_mem.sv
// Backing store: word array with per-byte write strobes and an async read port.
// The read port sees the array before the clock edge, so a same-cycle write
// to the word being read is not visible until the following cycle.
module aximm_resp_mem #(
   parameter int DW    = 128,
   parameter int DEPTH = 256
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DW-1:0]            wdata_i,
   input  logic [DW/8-1:0]          wstrb_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DW-1:0]            rdata_o
);

   logic [DW-1:0] mem_q [DEPTH];

   // Byte-enabled write; contents are intentionally never reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < DW/8; b++) begin
            if (wstrb_i[b]) mem_q[waddr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
         end
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/aximm_user_responder.sv
// AXI-MM slave responder backed by a local memory. One outstanding burst per
// direction; independent write (AW/W/B) and read (AR/R) state machines.
module aximm_user_responder #(
   parameter int AXI_TDATA_FACTOR = 2,
   parameter int MEM_DEPTH        = 256
) (
   input  logic                          clk_wr,
   input  logic                          rst_wr,
   input  logic [3:0]                    user_arid,
   input  logic [2:0]                    user_arsize,
   input  logic [7:0]                    user_arlen,
   input  logic [1:0]                    user_arburst,
   input  logic [31:0]                   user_araddr,
   input  logic                          user_arvalid,
   output logic                          user_arready,
   input  logic [3:0]                    user_awid,
   input  logic [2:0]                    user_awsize,
   input  logic [7:0]                    user_awlen,
   input  logic [1:0]                    user_awburst,
   input  logic [31:0]                   user_awaddr,
   input  logic                          user_awvalid,
   output logic                          user_awready,
   input  logic [3:0]                    user_wid,
   input  logic [64*AXI_TDATA_FACTOR-1:0] user_wdata,
   input  logic [15:0]                   user_wstrb,
   input  logic                          user_wlast,
   input  logic                          user_wvalid,
   output logic                          user_wready,
   output logic [3:0]                    user_rid,
   output logic [64*AXI_TDATA_FACTOR-1:0] user_rdata,
   output logic                          user_rlast,
   output logic [1:0]                    user_rresp,
   output logic                          user_rvalid,
   input  logic                          user_rready,
   output logic [3:0]                    user_bid,
   output logic [1:0]                    user_bresp,
   output logic                          user_bvalid,
   input  logic                          user_bready,
   output logic [31:0]                   responder_debug_status
);
   import aximm_resp_pkg::*;

   localparam int DW       = 64*AXI_TDATA_FACTOR;
   localparam int NB       = 8*AXI_TDATA_FACTOR;
   localparam int ADDR_LSB = $clog2(NB);
   localparam int IW       = $clog2(MEM_DEPTH);

   wr_state_e     wr_st_q, wr_st_d;
   rd_state_e     rd_st_q, rd_st_d;
   logic [3:0]    awid_q, awid_d, arid_q, arid_d;
   logic [IW-1:0] widx_q, widx_d, ridx_q, ridx_d;
   logic [7:0]    awlen_q, awlen_d, arlen_q, arlen_d;
   logic [7:0]    wbeat_q, wbeat_d, rbeat_q, rbeat_d;
   logic [1:0]    awburst_q, awburst_d, arburst_q, arburst_d;
   logic          werr_q, werr_d;
   logic [15:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
   logic          rdy_en_q;
   logic          mem_we, wlast_exp, rlast_exp;
   logic [DW-1:0] mem_rdata;

   // Size fields, wid, and address bits outside the word index carry no meaning here.
   logic unused_ok;
   assign unused_ok = ^{user_arsize, user_awsize, user_wid, user_awaddr, user_araddr, user_wstrb};

   assign wlast_exp = (wbeat_q == awlen_q);
   assign rlast_exp = (rbeat_q == arlen_q);

   // Write path: capture AW, write each W beat, then hold B until accepted.
   always_comb begin
      wr_st_d   = wr_st_q;
      awid_d    = awid_q;
      widx_d    = widx_q;
      awlen_d   = awlen_q;
      awburst_d = awburst_q;
      wbeat_d   = wbeat_q;
      werr_d    = werr_q;
      wr_cnt_d  = wr_cnt_q;
      mem_we    = 1'b0;
      case (wr_st_q)
         W_IDLE: if (user_awvalid && rdy_en_q) begin
            awid_d    = user_awid;
            widx_d    = user_awaddr[ADDR_LSB +: IW];
            awlen_d   = user_awlen;
            awburst_d = user_awburst;
            wbeat_d   = '0;
            werr_d    = burst_unsupported(user_awburst);
            wr_st_d   = W_DATA;
         end
         W_DATA: if (user_wvalid) begin
            mem_we = 1'b1;
            if (user_wlast != wlast_exp) werr_d = 1'b1;
            if (wlast_exp) begin
               wr_st_d = W_RESP;
            end else begin
               wbeat_d = wbeat_q + 1'b1;
               if (awburst_q != BURST_FIXED) widx_d = widx_q + 1'b1;
            end
         end
         W_RESP: if (user_bready) begin
            wr_st_d  = W_IDLE;
            wr_cnt_d = wr_cnt_q + 1'b1;
         end
         default: wr_st_d = W_IDLE;
      endcase
   end

   // Read path: capture AR, then stream beats with stall-stable outputs.
   always_comb begin
      rd_st_d   = rd_st_q;
      arid_d    = arid_q;
      ridx_d    = ridx_q;
      arlen_d   = arlen_q;
      arburst_d = arburst_q;
      rbeat_d   = rbeat_q;
      rd_cnt_d  = rd_cnt_q;
      case (rd_st_q)
         R_IDLE: if (user_arvalid && rdy_en_q) begin
            arid_d    = user_arid;
            ridx_d    = user_araddr[ADDR_LSB +: IW];
            arlen_d   = user_arlen;
            arburst_d = user_arburst;
            rbeat_d   = '0;
            rd_st_d   = R_DATA;
         end
         R_DATA: if (user_rready) begin
            if (rlast_exp) begin
               rd_st_d  = R_IDLE;
               rd_cnt_d = rd_cnt_q + 1'b1;
            end else begin
               rbeat_d = rbeat_q + 1'b1;
               if (arburst_q != BURST_FIXED) ridx_d = ridx_q + 1'b1;
            end
         end
         default: rd_st_d = R_IDLE;
      endcase
   end

   // State registers; rdy_en_q keeps the ready outputs low until the first
   // cycle after reset is released.
   always_ff @(posedge clk_wr) begin
      if (rst_wr) begin
         wr_st_q   <= W_IDLE;
         rd_st_q   <= R_IDLE;
         awid_q    <= '0;
         arid_q    <= '0;
         widx_q    <= '0;
         ridx_q    <= '0;
         awlen_q   <= '0;
         arlen_q   <= '0;
         awburst_q <= '0;
         arburst_q <= '0;
         wbeat_q   <= '0;
         rbeat_q   <= '0;
         werr_q    <= 1'b0;
         wr_cnt_q  <= '0;
         rd_cnt_q  <= '0;
         rdy_en_q  <= 1'b0;
      end else begin
         wr_st_q   <= wr_st_d;
         rd_st_q   <= rd_st_d;
         awid_q    <= awid_d;
         arid_q    <= arid_d;
         widx_q    <= widx_d;
         ridx_q    <= ridx_d;
         awlen_q   <= awlen_d;
         arlen_q   <= arlen_d;
         awburst_q <= awburst_d;
         arburst_q <= arburst_d;
         wbeat_q   <= wbeat_d;
         rbeat_q   <= rbeat_d;
         werr_q    <= werr_d;
         wr_cnt_q  <= wr_cnt_d;
         rd_cnt_q  <= rd_cnt_d;
         rdy_en_q  <= 1'b1;
      end
   end

   aximm_resp_mem #(.DW(DW), .DEPTH(MEM_DEPTH)) u_mem (
      .clk_i   (clk_wr),
      .we_i    (mem_we),
      .waddr_i (widx_q),
      .wdata_i (user_wdata),
      .wstrb_i (user_wstrb[NB-1:0]),
      .raddr_i (ridx_q),
      .rdata_o (mem_rdata)
   );

   assign user_awready = (wr_st_q == W_IDLE) && rdy_en_q;
   assign user_wready  = (wr_st_q == W_DATA);
   assign user_bvalid  = (wr_st_q == W_RESP);
   assign user_bid     = user_bvalid ? awid_q : 4'd0;
   assign user_bresp   = (user_bvalid && werr_q) ? RESP_SLVERR : RESP_OKAY;

   assign user_arready = (rd_st_q == R_IDLE) && rdy_en_q;
   assign user_rvalid  = (rd_st_q == R_DATA);
   assign user_rdata   = user_rvalid ? mem_rdata : '0;
   assign user_rid     = user_rvalid ? arid_q : 4'd0;
   assign user_rlast   = user_rvalid && rlast_exp;
   assign user_rresp   = (user_rvalid && burst_unsupported(arburst_q)) ? RESP_SLVERR : RESP_OKAY;

   assign responder_debug_status = {rd_cnt_q, wr_cnt_q};

endmodule

// File: tb/tb_aximm_user_responder.sv
// Directed bench for aximm_user_responder (default parameters).
module tb_aximm_user_responder;

   localparam int DW = 128;

   logic          clk_wr = 1'b0;
   logic          rst_wr = 1'b1;
   logic [3:0]    user_arid = '0, user_awid = '0, user_wid = '0;
   logic [2:0]    user_arsize = 3'd4, user_awsize = 3'd4;
   logic [7:0]    user_arlen = '0, user_awlen = '0;
   logic [1:0]    user_arburst = '0, user_awburst = '0;
   logic [31:0]   user_araddr = '0, user_awaddr = '0;
   logic          user_arvalid = 1'b0, user_awvalid = 1'b0;
   logic          user_arready, user_awready;
   logic [DW-1:0] user_wdata = '0;
   logic [15:0]   user_wstrb = '0;
   logic          user_wlast = 1'b0, user_wvalid = 1'b0, user_wready;
   logic [3:0]    user_rid, user_bid;
   logic [DW-1:0] user_rdata;
   logic          user_rlast, user_rvalid, user_bvalid;
   logic [1:0]    user_rresp, user_bresp;
   logic          user_rready = 1'b0, user_bready = 1'b0;
   logic [31:0]   responder_debug_status;

   aximm_user_responder #(.AXI_TDATA_FACTOR(2), .MEM_DEPTH(256)) dut (
      .clk_wr(clk_wr), .rst_wr(rst_wr),
      .user_arid(user_arid), .user_arsize(user_arsize), .user_arlen(user_arlen),
      .user_arburst(user_arburst), .user_araddr(user_araddr), .user_arvalid(user_arvalid),
      .user_arready(user_arready),
      .user_awid(user_awid), .user_awsize(user_awsize), .user_awlen(user_awlen),
      .user_awburst(user_awburst), .user_awaddr(user_awaddr), .user_awvalid(user_awvalid),
      .user_awready(user_awready),
      .user_wid(user_wid), .user_wdata(user_wdata), .user_wstrb(user_wstrb),
      .user_wlast(user_wlast), .user_wvalid(user_wvalid), .user_wready(user_wready),
      .user_rid(user_rid), .user_rdata(user_rdata), .user_rlast(user_rlast),
      .user_rresp(user_rresp), .user_rvalid(user_rvalid), .user_rready(user_rready),
      .user_bid(user_bid), .user_bresp(user_bresp), .user_bvalid(user_bvalid),
      .user_bready(user_bready),
      .responder_debug_status(responder_debug_status)
   );

   always #5 clk_wr = ~clk_wr;

   int vectors = 0;
   int miscompares = 0;
   logic [15:0]   exp_wr = 0, exp_rd = 0;
   logic [DW-1:0] d [4];
   logic [DW-1:0] e0, e1, f0, rdat;
   logic [3:0]    rid_s, bid_s;
   logic [1:0]    rresp_s, bresp_s;
   logic          rlast_s;

   // ---- drivers (bounded waits; an expired bound counts as a miscompare) ----
   task automatic step();
      @(posedge clk_wr); #1;
   endtask

   task automatic timeout(input string what);
      vectors++; miscompares++;
      $display("FAIL %s_timeout: handshake never happened", what);
   endtask

   task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      user_awid = id; user_awaddr = addr; user_awlen = len; user_awburst = burst; user_awvalid = 1'b1;
      while (user_awready !== 1'b1 && n < 20) begin step(); n++; end
      if (n >= 20) timeout("aw");
      step(); user_awvalid = 1'b0;
   endtask

   task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst);
      int n = 0;
      user_arid = id; user_araddr = addr; user_arlen = len; user_arburst = burst; user_arvalid = 1'b1;
      while (user_arready !== 1'b1 && n < 20) begin step(); n++; end
      if (n >= 20) timeout("ar");
      step(); user_arvalid = 1'b0;
   endtask

   task automatic w_beat(input logic [DW-1:0] data, input logic [15:0] strb, input logic last);
      int n = 0;
      user_wdata = data; user_wstrb = strb; user_wlast = last; user_wvalid = 1'b1;
      while (user_wready !== 1'b1 && n < 20) begin step(); n++; end
      if (n >= 20) timeout("w");
      step(); user_wvalid = 1'b0; user_wlast = 1'b0;
   endtask

   task automatic b_collect(output logic [3:0] id, output logic [1:0] resp);
      int n = 0;
      user_bready = 1'b1;
      while (user_bvalid !== 1'b1 && n < 20) begin step(); n++; end
      if (n >= 20) timeout("b");
      id = user_bid; resp = user_bresp;
      step(); user_bready = 1'b0;
   endtask

   task automatic r_collect(output logic [DW-1:0] data, output logic [1:0] resp, output logic last, output logic [3:0] id);
      int n = 0;
      user_rready = 1'b1;
      while (user_rvalid !== 1'b1 && n < 20) begin step(); n++; end
      if (n >= 20) timeout("r");
      data = user_rdata; resp = user_rresp; last = user_rlast; id = user_rid;
      step(); user_rready = 1'b0;
   endtask

   // ---- scenarios ----
   task automatic test_reset();
      rst_wr = 1'b1;
      repeat (3) step();
      vectors++; if ({user_awready, user_arready, user_wready, user_rvalid, user_bvalid, user_rlast} !== 6'b0) begin
         miscompares++; $display("FAIL reset_ctrl got=%b exp=000000", {user_awready, user_arready, user_wready, user_rvalid, user_bvalid, user_rlast}); end
      vectors++; if (user_rdata !== '0 || user_rid !== 4'd0 || user_bid !== 4'd0) begin
         miscompares++; $display("FAIL reset_data rdata=%h rid=%h bid=%h exp=0", user_rdata, user_rid, user_bid); end
      vectors++; if (responder_debug_status !== 32'd0) begin
         miscompares++; $display("FAIL reset_debug got=%h exp=0", responder_debug_status); end
      rst_wr = 1'b0; #1;
      vectors++; if ({user_awready, user_arready} !== 2'b00) begin
         miscompares++; $display("FAIL ready_before_edge got=%b exp=00", {user_awready, user_arready}); end
      step();
      vectors++; if ({user_awready, user_arready} !== 2'b11) begin
         miscompares++; $display("FAIL ready_after_release got=%b exp=11", {user_awready, user_arready}); end
   endtask

   task automatic test_write_burst();
      aw_send(4'd3, 32'h20, 8'd3, 2'b01);
      for (int i = 0; i < 4; i++) w_beat(d[i], 16'hFFFF, i == 3);
      b_collect(bid_s, bresp_s);
      exp_wr++;
      vectors++; if (bid_s !== 4'd3) begin miscompares++; $display("FAIL wr_bid got=%0d exp=3", bid_s); end
      vectors++; if (bresp_s !== 2'b00) begin miscompares++; $display("FAIL wr_bresp got=%b exp=00", bresp_s); end
      vectors++; if (responder_debug_status !== {exp_rd, exp_wr}) begin
         miscompares++; $display("FAIL wr_count got=%h exp=%h", responder_debug_status, {exp_rd, exp_wr}); end
   endtask

   task automatic test_read_stall();
      ar_send(4'd5, 32'h20, 8'd3, 2'b01);
      vectors++; if (user_arready !== 1'b0) begin miscompares++; $display("FAIL arready_busy got=%b exp=0", user_arready); end
      for (int k = 0; k < 4; k++) begin
         user_rready = 1'b0;
         vectors++; if (user_rvalid !== 1'b1 || user_rdata !== d[k]) begin
            miscompares++; $display("FAIL rd_beat%0d valid=%b data=%h exp=%h", k, user_rvalid, user_rdata, d[k]); end
         step();
         vectors++; if (user_rdata !== d[k] || user_rid !== 4'd5) begin
            miscompares++; $display("FAIL rd_stall%0d data=%h rid=%0d exp=%h/5", k, user_rdata, user_rid, d[k]); end
         vectors++; if (user_rlast !== (k == 3) || user_rresp !== 2'b00) begin
            miscompares++; $display("FAIL rd_last%0d rlast=%b rresp=%b exp=%b/00", k, user_rlast, user_rresp, k == 3); end
         user_rready = 1'b1;
         step();
      end
      user_rready = 1'b0;
      exp_rd++;
      vectors++; if (user_rvalid !== 1'b0) begin miscompares++; $display("FAIL rd_done rvalid=%b exp=0", user_rvalid); end
      vectors++; if (responder_debug_status !== {exp_rd, exp_wr}) begin
         miscompares++; $display("FAIL rd_count got=%h exp=%h", responder_debug_status, {exp_rd, exp_wr}); end
   endtask

   task automatic test_strobe();
      aw_send(4'd1, 32'h10, 8'd0, 2'b01);
      w_beat('0, 16'hFFFF, 1'b1);
      b_collect(bid_s, bresp_s);
      aw_send(4'd1, 32'h10, 8'd0, 2'b01);
      w_beat({DW{1'b1}}, 16'h00FF, 1'b1);
      b_collect(bid_s, bresp_s);
      exp_wr += 2;
      ar_send(4'd1, 32'h10, 8'd0, 2'b01);
      r_collect(rdat, rresp_s, rlast_s, rid_s);
      exp_rd++;
      vectors++; if (rdat !== {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}) begin
         miscompares++; $display("FAIL strobe_data got=%h exp=0000000000000000ffffffffffffffff", rdat); end
      vectors++; if (rlast_s !== 1'b1) begin miscompares++; $display("FAIL strobe_rlast got=%b exp=1", rlast_s); end
   endtask

   task automatic test_slverr();
      aw_send(4'd2, 32'h80, 8'd1, 2'b01);
      w_beat(d[0], 16'hFFFF, 1'b1);
      w_beat(d[1], 16'hFFFF, 1'b1);
      b_collect(bid_s, bresp_s);
      exp_wr++;
      vectors++; if (bresp_s !== 2'b10 || bid_s !== 4'd2) begin
         miscompares++; $display("FAIL early_wlast bresp=%b bid=%0d exp=10/2", bresp_s, bid_s); end
      ar_send(4'd4, 32'h20, 8'd1, 2'b10);
      for (int k = 0; k < 2; k++) begin
         r_collect(rdat, rresp_s, rlast_s, rid_s);
         vectors++; if (rresp_s !== 2'b10 || rdat !== d[k] || rlast_s !== (k == 1)) begin
            miscompares++; $display("FAIL burst10_rd%0d rresp=%b data=%h rlast=%b exp=10/%h/%b", k, rresp_s, rdat, rlast_s, d[k], k == 1); end
      end
      exp_rd++;
   endtask

   task automatic test_wrap();
      aw_send(4'd7, 32'hFF0, 8'd1, 2'b01);
      w_beat(e0, 16'hFFFF, 1'b0);
      w_beat(e1, 16'hFFFF, 1'b1);
      b_collect(bid_s, bresp_s);
      exp_wr++;
      vectors++; if (bresp_s !== 2'b00) begin miscompares++; $display("FAIL wrap_bresp got=%b exp=00", bresp_s); end
      ar_send(4'd7, 32'h0, 8'd0, 2'b01);
      r_collect(rdat, rresp_s, rlast_s, rid_s);
      exp_rd++;
      vectors++; if (rdat !== e1) begin miscompares++; $display("FAIL wrap_word0 got=%h exp=%h", rdat, e1); end
      ar_send(4'd7, 32'hFF0, 8'd1, 2'b01);
      r_collect(rdat, rresp_s, rlast_s, rid_s);
      vectors++; if (rdat !== e0) begin miscompares++; $display("FAIL wrap_rd0 got=%h exp=%h", rdat, e0); end
      r_collect(rdat, rresp_s, rlast_s, rid_s);
      vectors++; if (rdat !== e1 || rlast_s !== 1'b1) begin
         miscompares++; $display("FAIL wrap_rd1 got=%h rlast=%b exp=%h/1", rdat, rlast_s, e1); end
      exp_rd++;
      vectors++; if (responder_debug_status !== {exp_rd, exp_wr}) begin
         miscompares++; $display("FAIL wrap_count got=%h exp=%h", responder_debug_status, {exp_rd, exp_wr}); end
   endtask

   task automatic test_reset_mid_read();
      ar_send(4'd9, 32'h20, 8'd7, 2'b01);
      user_rready = 1'b1;
      step(); step();
      vectors++; if (user_rvalid !== 1'b1 || user_rdata !== d[2]) begin
         miscompares++; $display("FAIL midrd_beat2 valid=%b data=%h exp=1/%h", user_rvalid, user_rdata, d[2]); end
      rst_wr = 1'b1; user_rready = 1'b0;
      step();
      vectors++; if ({user_rvalid, user_arready, user_rlast} !== 3'b000 || user_rdata !== '0) begin
         miscompares++; $display("FAIL midrd_reset rvalid/arready/rlast=%b rdata=%h exp=000/0", {user_rvalid, user_arready, user_rlast}, user_rdata); end
      vectors++; if (responder_debug_status !== 32'd0) begin
         miscompares++; $display("FAIL midrd_debug got=%h exp=0", responder_debug_status); end
      rst_wr = 1'b0;
      exp_wr = 0; exp_rd = 0;
      ar_send(4'd6, 32'h20, 8'd0, 2'b01);
      r_collect(rdat, rresp_s, rlast_s, rid_s);
      exp_rd++;
      vectors++; if (rdat !== d[0] || rid_s !== 4'd6 || rlast_s !== 1'b1) begin
         miscompares++; $display("FAIL post_reset_rd data=%h rid=%0d rlast=%b exp=%h/6/1", rdat, rid_s, rlast_s, d[0]); end
      vectors++; if (responder_debug_status !== {exp_rd, exp_wr}) begin
         miscompares++; $display("FAIL post_reset_count got=%h exp=%h", responder_debug_status, {exp_rd, exp_wr}); end
   endtask

   task automatic test_same_cycle();
      ar_send(4'd1, 32'h20, 8'd0, 2'b01);
      aw_send(4'd1, 32'h20, 8'd0, 2'b01);
      user_wdata = f0; user_wstrb = 16'hFFFF; user_wlast = 1'b1; user_wvalid = 1'b1;
      user_rready = 1'b1;
      #1;
      vectors++; if (user_wready !== 1'b1 || user_rvalid !== 1'b1 || user_rdata !== d[0]) begin
         miscompares++; $display("FAIL same_cycle wready=%b rvalid=%b data=%h exp=1/1/%h", user_wready, user_rvalid, user_rdata, d[0]); end
      step();
      user_wvalid = 1'b0; user_wlast = 1'b0; user_rready = 1'b0;
      b_collect(bid_s, bresp_s);
      ar_send(4'd1, 32'h20, 8'd0, 2'b01);
      r_collect(rdat, rresp_s, rlast_s, rid_s);
      vectors++; if (rdat !== f0) begin miscompares++; $display("FAIL same_cycle_after got=%h exp=%h", rdat, f0); end
   endtask

   initial begin
      for (int i = 0; i < 4; i++) d[i] = {4{32'hC0DE_0000 + 32'(i)}};
      e0 = {4{32'hE0E0_0000}};
      e1 = {4{32'hE1E1_0001}};
      f0 = {4{32'hF00D_F00D}};
      test_reset();
      test_write_burst();
      test_read_stall();
      test_strobe();
      test_slverr();
      test_wrap();
      test_reset_mid_read();
      test_same_cycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

endmodule
